// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// A shift-add multiplier and a restoring divider share one 64-bit
// accumulator and retire one bit per clock. Divide-by-zero and signed
// overflow are resolved when the operation is accepted, with no iteration.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     opd_q, opd_d;      // mul: multiplicand magnitude; div: divisor magnitude
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                busy_q, done_q;

    logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s;
    logic                div_zero_s, div_ovf_s;
    logic [2*XLEN-1:0]   mul_step_s, div_step_s, step_s;
    logic [XLEN:0]       mul_sum_s, div_trial_s;
    logic [CNT_W-1:0]    cnt_dec_s;

    // Apply the sign fixup to a finished accumulator and pick the result word.
    function automatic logic [31:0] fixup(input logic [2:0] f3, input logic [63:0] acc,
                                          input logic neg_res, input logic neg_rem);
        logic [63:0] prod;
        logic [31:0] quo;
        logic [31:0] rem;
        prod = neg_res ? (64'd0 - acc) : acc;
        quo  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
        rem  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
        case (f3)
            3'b000:                  fixup = prod[31:0];
            3'b001, 3'b010, 3'b011:  fixup = prod[63:32];
            3'b100, 3'b101:          fixup = quo;
            3'b110, 3'b111:          fixup = rem;
            default:                 fixup = 32'd0;
        endcase
    endfunction

    // Operand signedness per opcode, sign flags and magnitudes of the new operands.
    always_comb begin
        a_signed_s = (Funct3 != 3'b011) && (Funct3 != 3'b101) && (Funct3 != 3'b111);
        b_signed_s = a_signed_s && (Funct3 != 3'b010);
        a_neg_s    = a_signed_s && SrcA[XLEN-1];
        b_neg_s    = b_signed_s && SrcB[XLEN-1];
        mag_a_s    = a_neg_s ? (32'd0 - SrcA) : SrcA;
        mag_b_s    = b_neg_s ? (32'd0 - SrcB) : SrcB;
        div_zero_s = Funct3[2] && (SrcB == 32'd0);
        div_ovf_s  = Funct3[2] && !Funct3[0] && (SrcA == 32'h8000_0000) && (SrcB == 32'hFFFF_FFFF);
    end

    // One shift-add multiply step: conditional add into the upper half, then shift right.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
        mul_step_s = {mul_sum_s, acc_q[31:1]};
    end

    // One restoring divide step: shift {rem, quo} left, trial-subtract the divisor.
    always_comb begin
        div_trial_s = {acc_q[63:32], acc_q[31]};
        if (div_trial_s >= {1'b0, opd_q}) begin
            div_step_s = {div_trial_s[31:0] - opd_q, acc_q[30:0], 1'b1};
        end else begin
            div_step_s = {div_trial_s[31:0], acc_q[30:0], 1'b0};
        end
    end

    // Select the step for the latched opcode and decrement the counter, saturating at zero.
    always_comb begin
        step_s = f3_q[2] ? div_step_s : mul_step_s;
        if (cnt_q != '0) begin
            cnt_dec_s = cnt_q - 1'b1;
        end else begin
            cnt_dec_s = '0;
        end
    end

    // Next-state logic: accept, special-case resolution, iteration and completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    f3_d      = Funct3;
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    cnt_d     = CNT_W'(XLEN);
                    if (Funct3[2]) begin
                        acc_d = {32'd0, mag_a_s};
                        opd_d = mag_b_s;
                    end else begin
                        acc_d = {32'd0, mag_b_s};
                        opd_d = mag_a_s;
                    end
                    if (div_zero_s) begin
                        state_d  = DONE;
                        result_d = Funct3[1] ? SrcA : 32'hFFFF_FFFF;
                    end else if (div_ovf_s) begin
                        state_d  = DONE;
                        result_d = Funct3[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d  = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = step_s;
                cnt_d = cnt_dec_s;
                if (cnt_dec_s == '0) begin
                    state_d  = DONE;
                    result_d = fixup(f3_q, step_s, neg_res_q, neg_rem_q);
                end else begin
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            f3_q      <= 3'd0;
            acc_q     <= 64'd0;
            opd_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, random operations
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model straight from RV32M arithmetic rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (!f3[2]) begin
            ea = (f3 != 3'b011) ? {{32{a[31]}}, a} : {32'd0, a};
            eb = (f3 == 3'b000 || f3 == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
            p  = ea * eb;
            return (f3 == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'd0 : 32'h8000_0000;
        case (f3)
            3'b100:  return 32'(sa / sb);
            3'b101:  return a / b;
            3'b110:  return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return f3[2] && ((b == 32'd0) ||
               (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Called #1 after an edge; counts edges until Done, and Busy cycles seen meanwhile.
    task automatic wait_done(output int cyc, output int busy_n);
        cyc = 0;
        busy_n = 0;
        while (Done !== 1'b1 && cyc < 50) begin
            if (Busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1;
        Funct3 = f3;
        SrcA = a;
        SrcB = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        int busy_n;
        int lat;
        lat = is_special(f3, a, b) ? 0 : 32;
        issue(f3, a, b);
        wait_done(cyc, busy_n);
        chk({name, "_latency"}, 32'(cyc), 32'(lat));
        chk({name, "_busycycles"}, 32'(busy_n), 32'(lat));
        chk({name, "_result"}, Result, exp);
        chk({name, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_done_pulse"}, {31'd0, Done}, 32'd0);
        chk({name, "_result_hold"}, Result, exp);
    endtask

    initial begin
        int cyc;
        int busy_n;
        int dcount;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        int sel;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'h0000_000E};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'h0000_0002};
        vecs[8]  = '{3'b101, 32'h1234,       32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'b110, 32'h1234,       32'd0,         32'h0000_1234};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};

        rst_n = 1'b0;
        Start = 1'b0;
        Funct3 = 3'd0;
        SrcA = 32'd0;
        SrcB = 32'd0;
        #12;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_done", {31'd0, Done}, 32'd0);
        chk("reset_result", Result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 48; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                rb = 32'd0;
            end else if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                rb = 32'($urandom_range(1, 15));
            end else begin
                rb = $urandom;
            end
            run_op($sformatf("rnd%0d_f%0d_%h_%h", i, rf3, ra, rb), rf3, ra, rb,
                   ref_model(rf3, ra, rb));
        end

        // Start during RUN is ignored, then back-to-back Start in the Done cycle
        issue(3'b000, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        Start = 1'b1;
        Funct3 = 3'b100;
        SrcA = 32'd100;
        SrcB = 32'd7;
        @(posedge clk);
        #1;
        Start = 1'b0;
        wait_done(cyc, busy_n);
        chk("ignore_latency", 32'(cyc + 10), 32'd32);
        chk("ignore_result", Result, 32'h0000_000F);
        Start = 1'b1;
        Funct3 = 3'b000;
        SrcA = 32'd6;
        SrcB = 32'd7;
        @(posedge clk);
        #1;
        Start = 1'b0;
        chk("b2b_busy", {31'd0, Busy}, 32'd1);
        chk("b2b_done_drop", {31'd0, Done}, 32'd0);
        wait_done(cyc, busy_n);
        chk("b2b_latency", 32'(cyc), 32'd32);
        chk("b2b_result", Result, 32'h0000_002A);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an operation
        issue(3'b000, 32'd9, 32'd9);
        repeat (16) @(posedge clk);
        #1;
        chk("midrun_busy_before", {31'd0, Busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_busy", {31'd0, Busy}, 32'd0);
        chk("midrun_done", {31'd0, Done}, 32'd0);
        chk("midrun_result", Result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1 || Busy === 1'b1) dcount++;
        end
        chk("midrun_no_done", 32'(dcount), 32'd0);
        run_op("after_reset_mul", 3'b000, 32'd2, 32'd2, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits beside the main ALU and takes the same operand pair: SrcA from the register file and SrcB from the ALU operand mux (register or immediate).
- Control stalls the PC while Busy is high. Result is then selected onto the ALUResult path when Done is high.
- Implemented as a shift-add multiplier and a restoring divider, one bit per clock.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Start  input  1  operation request, sampled on rising edge of clk
Funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  32  operand A / dividend
SrcB  input  32  operand B / divisor (from ALU operand mux output)
Busy  output  1  high while an operation is iterating
Done  output  1  one-cycle pulse: Result is valid
Result  output  32  selected 32-bit result, held until next accepted Start

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low. rst_n low forces state IDLE, Busy=0, Done=0, Result=0 and clears the counter and internal registers, regardless of the current state.
- States: IDLE, RUN, DONE. Busy=1 only in RUN. Done=1 only in DONE.
- Accept rule: Start is accepted at edge E0 only when state is IDLE or DONE.
  - On accept, latch Funct3 and the operands.
  - Latch the sign flags, then convert the operands to magnitudes:
    - MUL/MULH/DIV/REM: both operands treated as signed.
    - MULHSU: A signed, B unsigned.
    - MULHU/DIVU/REMU: both unsigned.
  - Load counter = 32.
- Start while in RUN is ignored: no restart and no operand change.
- Special cases are resolved at E0 with no iteration (IDLE/DONE -> DONE). Done is high in the cycle following E0.
  - Divide by zero (SrcB=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> SrcA.
  - Signed overflow (DIV/REM with SrcA=0x80000000, SrcB=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Normal case: IDLE/DONE -> RUN at E0. RUN performs one iteration per edge, E1..E32, decrementing the counter each edge.
  - Multiply iteration: if the multiplier LSB is 1, add the multiplicand to the upper half of a 64-bit accumulator. Shift the accumulator and multiplier right by 1 (the carry is kept in bit 63).
  - Divide iteration: shift {remainder, quotient} left by 1 and trial-subtract the divisor from the remainder. If the difference is >= 0, keep it and set the quotient LSB to 1; otherwise restore the remainder.
- At E32 (counter reaches 0): RUN -> DONE, and Result is registered after sign fixup.
  - MUL: product[31:0]. MULH/MULHSU/MULHU: product[63:32]. The 64-bit product is negated when the operand signs differ, before bit selection.
  - DIV: quotient, negated if the signs differ. REM: remainder, negated if the dividend was negative. DIVU/REMU: unsigned, no fixup.
- Done timing:
  - Done is high for exactly one cycle: the cycle between E32 and E33 (normal case) or between E0 and E1 (special case).
  - DONE -> IDLE on the next edge unless a new Start is accepted.
- Back-to-back: a Start sampled while in DONE is accepted. Done still deasserts after one cycle, and Busy rises at the same edge.
- Result holds its value through IDLE. It changes only when the next operation completes, or on reset.
- Counter wrap: the counter never decrements below 0. RUN always exits at count 0.
- A reset in RUN abandons the operation. No Done is produced for it.

Test Plan:
1. Reset, then MUL with SrcA=7, SrcB=0xFFFFFFFD -> Busy high for 32 cycles; Done pulses once after E32 with Result=0xFFFFFFEB; Busy=0 during Done.
2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> Result=0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
3. DIV SrcA=0xFFFFFFF9 (-7), SrcB=2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100/7 -> 0x0000000E. REMU -> 0x00000002.
4. Special cases, each with Done in the cycle after E0 and Busy never high:
   - DIVU 0x1234/0 -> 0xFFFFFFFF.
   - REM 0x1234/0 -> 0x00001234.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM with the same operands -> 0.
5. Start MUL 3*5, then reassert Start with DIV at cycle 10 of RUN -> the second Start is ignored; Result=0x0000000F after E32. Then assert Start during the Done cycle -> accepted, and Busy rises next cycle.
6. Drive rst_n low mid-RUN (cycle 16) -> Busy, Done and Result go to 0 immediately (asynchronous). No Done pulse follows. A subsequent MUL 2*2 completes normally with Result=4.
